// File: rtl/mem_pkg.sv
// Shared definitions for the aligned memory access controller.
// Holds the access-size encodings, the controller state encoding, the
// byte-lane geometry of the 32-bit memory bus, the default timeout and a
// helper that classifies a request as misaligned.
package mem_pkg;

  localparam int BYTE_W          = 8;
  localparam int LANES           = 4;
  localparam int WORD_W          = BYTE_W * LANES;
  localparam int TIMEOUT_DEFAULT = 16;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_DONE = 2'b10,
    ST_ERR  = 2'b11
  } state_t;

  // Reserved size is treated as misaligned so it takes the same error path.
  function automatic logic is_misaligned(input logic [1:0] size,
                                         input logic [1:0] addr_lo);
    logic bad;
    bad = 1'b0;
    case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = addr_lo[0];
      SZ_WORD: bad = (addr_lo != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/byte_lane_align.sv
// Combinational byte-lane steering between a right-justified CPU view and
// the little-endian 32-bit memory bus (byte at offset k on bits [8k+7:8k]).
// Ports:
//   addr_lo    in  2   byte offset within the word
//   size       in  2   access size encoding (mem_pkg::size_t)
//   wdata      in  32  right-justified store data
//   mem_din    in  32  word returned by memory
//   rdata_ext  out 32  extracted load data, zero-extended
//   mem_wdata  out 32  store data replicated across the lanes
//   mem_be     out 4   byte enables for the store
module byte_lane_align
  import mem_pkg::*;
(
  input  logic [1:0]        addr_lo,
  input  logic [1:0]        size,
  input  logic [WORD_W-1:0] wdata,
  input  logic [WORD_W-1:0] mem_din,
  output logic [WORD_W-1:0] rdata_ext,
  output logic [WORD_W-1:0] mem_wdata,
  output logic [LANES-1:0]  mem_be
);

  logic [WORD_W-1:0] din_byte_sh;
  logic [WORD_W-1:0] din_half_sh;

  // Bring the addressed lane(s) down to bit 0; the mask below zero-fills.
  assign din_byte_sh = mem_din >> (addr_lo * BYTE_W);
  assign din_half_sh = mem_din >> ({addr_lo[1], 1'b0} * BYTE_W);

  always_comb begin
    rdata_ext = '0;
    mem_wdata = '0;
    mem_be    = '0;
    case (size)
      SZ_BYTE: begin
        rdata_ext = din_byte_sh & {{(WORD_W-BYTE_W){1'b0}}, {BYTE_W{1'b1}}};
        mem_wdata = {LANES{wdata[BYTE_W-1:0]}};
        mem_be    = 4'b0001 << addr_lo;
      end
      SZ_HALF: begin
        rdata_ext = din_half_sh & {{(WORD_W-2*BYTE_W){1'b0}}, {(2*BYTE_W){1'b1}}};
        mem_wdata = {(LANES/2){wdata[2*BYTE_W-1:0]}};
        mem_be    = addr_lo[1] ? 4'b1100 : 4'b0011;
      end
      SZ_WORD: begin
        rdata_ext = mem_din;
        mem_wdata = wdata;
        mem_be    = 4'b1111;
      end
      default: begin
        rdata_ext = '0;
        mem_wdata = '0;
        mem_be    = '0;
      end
    endcase
  end

endmodule

// File: rtl/mem_align_ctrl.sv
// Memory access controller: accepts one load/store request at a time,
// rejects misaligned requests, drives a request/acknowledge (MFA/MOC)
// memory handshake with lane steering and byte enables, and aborts an
// access that receives no acknowledge within TIMEOUT_CYCLES wait cycles.
// Ports:
//   CLK, RST                 clock, synchronous active-high reset
//   REQ, RW, ADDR,           request (RW 1=load), byte address,
//   DATA_SIZE, WDATA         size encoding, right-justified store data
//   BUSY, DONE,              access in flight, success pulse,
//   ALIGN_ERR, TMO_ERR       misalignment pulse, timeout pulse
//   RDATA, RD_SIZE           last load data (zero-filled) and its size
//   MEM_MFA, MEM_RW,         memory request strobe and direction,
//   MEM_ADDR, MEM_WDATA,     word address, lane-replicated store data,
//   MEM_BE                   byte enables (zero outside WAIT)
//   MEM_DIN, MEM_MOC         memory read word and acknowledge
module mem_align_ctrl
  import mem_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        REQ,
  input  logic        RW,
  input  logic [31:0] ADDR,
  input  logic [1:0]  DATA_SIZE,
  input  logic [31:0] WDATA,
  output logic        BUSY,
  output logic        DONE,
  output logic        ALIGN_ERR,
  output logic        TMO_ERR,
  output logic [31:0] RDATA,
  output logic [1:0]  RD_SIZE,
  output logic        MEM_MFA,
  output logic        MEM_RW,
  output logic [31:0] MEM_ADDR,
  output logic [31:0] MEM_WDATA,
  output logic [3:0]  MEM_BE,
  input  logic [31:0] MEM_DIN,
  input  logic        MEM_MOC
);

  localparam int                CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0]  TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              tmo_q, tmo_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [1:0]        rd_size_q, rd_size_d;

  // Latched request; only meaningful while an access is in flight.
  logic              rw_q, rw_d;
  logic [31:0]       addr_q, addr_d;
  logic [1:0]        size_q, size_d;
  logic [31:0]       wdata_q, wdata_d;

  logic [31:0]       lane_rdata;
  logic [31:0]       lane_wdata;
  logic [3:0]        lane_be;

  byte_lane_align u_lane (
    .addr_lo   (addr_q[1:0]),
    .size      (size_q),
    .wdata     (wdata_q),
    .mem_din   (MEM_DIN),
    .rdata_ext (lane_rdata),
    .mem_wdata (lane_wdata),
    .mem_be    (lane_be)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    tmo_d     = tmo_q;
    rdata_d   = rdata_q;
    rd_size_d = rd_size_q;
    rw_d      = rw_q;
    addr_d    = addr_q;
    size_d    = size_q;
    wdata_d   = wdata_q;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (REQ) begin
          if (is_misaligned(DATA_SIZE, ADDR[1:0])) begin
            tmo_d   = 1'b0;
            state_d = ST_ERR;
          end else begin
            rw_d    = RW;
            addr_d  = ADDR;
            size_d  = DATA_SIZE;
            wdata_d = WDATA;
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        // Acknowledge is tested before the timeout so a late MOC still wins.
        if (MEM_MOC) begin
          if (rw_q) begin
            rdata_d   = lane_rdata;
            rd_size_d = size_q;
          end
          state_d = ST_DONE;
        end else if (cnt_q == TMO_LAST) begin
          tmo_d   = 1'b1;
          state_d = ST_ERR;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      ST_ERR:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      tmo_q     <= 1'b0;
      rdata_q   <= '0;
      rd_size_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      tmo_q     <= tmo_d;
      rdata_q   <= rdata_d;
      rd_size_q <= rd_size_d;
    end
  end

  always_ff @(posedge CLK) begin
    rw_q    <= rw_d;
    addr_q  <= addr_d;
    size_q  <= size_d;
    wdata_q <= wdata_d;
  end

  assign BUSY      = (state_q != ST_IDLE);
  assign DONE      = (state_q == ST_DONE);
  assign ALIGN_ERR = (state_q == ST_ERR) && !tmo_q;
  assign TMO_ERR   = (state_q == ST_ERR) && tmo_q;
  assign RDATA     = rdata_q;
  assign RD_SIZE   = rd_size_q;
  assign MEM_MFA   = (state_q == ST_WAIT);
  assign MEM_RW    = rw_q;
  assign MEM_ADDR  = {addr_q[31:2], 2'b00};
  assign MEM_WDATA = lane_wdata;
  assign MEM_BE    = (state_q == ST_WAIT) ? lane_be : 4'b0000;

endmodule

// File: tb/tb_mem_align_ctrl.sv
module tb_mem_align_ctrl;

  localparam int TMO = 16;

  logic        clk;
  logic        rst;
  logic        req;
  logic        rw;
  logic [31:0] addr;
  logic [1:0]  data_size;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic        align_err;
  logic        tmo_err;
  logic [31:0] rdata;
  logic [1:0]  rd_size;
  logic        mem_mfa;
  logic        mem_rw;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic [31:0] mem_din;
  logic        mem_moc;

  int checks   = 0;
  int failures = 0;

  // Golden byte memory written straight from each store request, and the
  // memory as the DUT actually writes it through MEM_BE/MEM_WDATA.
  logic [7:0]  gmem [64];
  logic [7:0]  dmem [64];
  logic [31:0] exp_rdata;
  logic [1:0]  exp_rd_size;

  mem_align_ctrl #(.TIMEOUT_CYCLES(TMO)) dut (
    .CLK(clk), .RST(rst), .REQ(req), .RW(rw), .ADDR(addr),
    .DATA_SIZE(data_size), .WDATA(wdata),
    .BUSY(busy), .DONE(done), .ALIGN_ERR(align_err), .TMO_ERR(tmo_err),
    .RDATA(rdata), .RD_SIZE(rd_size),
    .MEM_MFA(mem_mfa), .MEM_RW(mem_rw), .MEM_ADDR(mem_addr),
    .MEM_WDATA(mem_wdata), .MEM_BE(mem_be),
    .MEM_DIN(mem_din), .MEM_MOC(mem_moc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] dword(input logic [31:0] a);
    logic [31:0] w;
    w = 0;
    for (int k = 0; k < 4; k++) w = w | (32'(dmem[{a[5:2], 2'(k)}]) << (8 * k));
    return w;
  endfunction

  // One complete access. moc_at = WAIT cycle number (1-based) on which the
  // memory acknowledges; any value above TMO means it never does.
  task automatic access(input logic r, input logic [31:0] a, input logic [1:0] sz,
                        input logic [31:0] wd, input int moc_at);
    int          nbytes;
    logic        mis;
    logic [31:0] exp_be;
    logic [31:0] exp_wd;
    logic [31:0] val;
    logic        acked;
    nbytes = 1 << sz;
    mis = (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00);
    req = 1'b1; rw = r; addr = a; data_size = sz; wdata = wd; mem_moc = 1'b0;
    tick();
    req = 1'b0; rw = $urandom; addr = $urandom; data_size = $urandom; wdata = $urandom;
    if (mis) begin
      check("align_err", 32'(align_err), 1);
      check("align_tmo", 32'(tmo_err), 0);
      check("align_mfa", 32'(mem_mfa), 0);
      check("align_busy", 32'(busy), 1);
      tick();
      check("align_pulse", 32'(align_err), 0);
      check("align_idle", 32'(busy), 0);
      return;
    end
    exp_be = ((32'd1 << nbytes) - 1) << a[1:0];
    if (sz == 2'b00)      exp_wd = 32'(wd[7:0]) * 32'h01010101;
    else if (sz == 2'b01) exp_wd = 32'(wd[15:0]) * 32'h00010001;
    else                  exp_wd = wd;
    acked = 1'b0;
    for (int n = 1; n <= TMO; n++) begin
      check("wait_mfa", 32'(mem_mfa), 1);
      check("wait_done", 32'(done), 0);
      check("wait_tmo", 32'(tmo_err), 0);
      if (n == 1) begin
        check("mem_addr", mem_addr, {a[31:2], 2'b00});
        check("mem_rw", 32'(mem_rw), 32'(r));
        check("mem_be", 32'(mem_be), exp_be);
        if (!r) check("mem_wdata", mem_wdata, exp_wd);
      end
      mem_din = dword(a);
      mem_moc = (n == moc_at);
      if (mem_moc && !r)
        for (int k = 0; k < 4; k++)
          if (mem_be[k]) dmem[{a[5:2], 2'(k)}] = mem_wdata[8*k +: 8];
      tick();
      if (mem_moc) begin
        acked = 1'b1;
        mem_moc = 1'b0;
        mem_din = $urandom;
        break;
      end
    end
    if (acked) begin
      if (r) begin
        val = 0;
        for (int i = 0; i < nbytes; i++) val = val | (32'(gmem[6'(a + i)]) << (8 * i));
        exp_rdata = val;
        exp_rd_size = sz;
      end else begin
        for (int i = 0; i < nbytes; i++) gmem[6'(a + i)] = wd[8*i +: 8];
      end
      check("done_pulse", 32'(done), 1);
      check("done_tmo", 32'(tmo_err), 0);
      check("done_busy", 32'(busy), 1);
      check("rdata", rdata, exp_rdata);
      check("rd_size", 32'(rd_size), 32'(exp_rd_size));
    end else begin
      check("tmo_err", 32'(tmo_err), 1);
      check("tmo_align", 32'(align_err), 0);
      check("tmo_done", 32'(done), 0);
      check("tmo_rdata", rdata, exp_rdata);
    end
    tick();
    check("end_idle", 32'(busy), 0);
    check("end_done", 32'(done), 0);
    check("end_be", 32'(mem_be), 0);
  endtask

  initial begin
    int dcnt;
    int mcnt;
    for (int i = 0; i < 64; i++) begin
      gmem[i] = 8'($urandom);
      dmem[i] = gmem[i];
    end
    exp_rdata = 0; exp_rd_size = 0;
    rst = 1'b1; req = 1'b0; rw = 1'b0; addr = 0; data_size = 0; wdata = 0;
    mem_din = 0; mem_moc = 1'b0;
    tick(); tick(); tick();
    rst = 1'b0;
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_errs", {30'd0, align_err, tmo_err}, 0);
    check("rst_mfa", 32'(mem_mfa), 0);
    check("rst_be", 32'(mem_be), 0);
    check("rst_rdata", rdata, 0);
    check("rst_rd_size", 32'(rd_size), 0);

    // Byte load with a known word in memory.
    {dmem[3], dmem[2], dmem[1], dmem[0]} = 32'hF0E47492;
    {gmem[3], gmem[2], gmem[1], gmem[0]} = 32'hF0E47492;
    access(1'b1, 32'h102, 2'b00, 32'h0, 1);
    check("byte_load_e4", rdata, 32'h000000E4);

    // Halfword store to the upper half; RDATA keeps the byte load value.
    access(1'b0, 32'h202, 2'b01, 32'h0000FF03, 1);
    check("hstore_rdata", rdata, 32'h000000E4);

    access(1'b1, 32'h301, 2'b10, 32'h0, 1);
    access(1'b1, 32'h400, 2'b10, 32'h0, TMO + 5);
    access(1'b1, 32'h404, 2'b10, 32'h0, TMO);

    // Reset on the second WAIT cycle discards the access.
    req = 1'b1; rw = 1'b1; addr = 32'h8; data_size = 2'b10; mem_moc = 1'b0;
    tick();
    req = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rstw_mfa", 32'(mem_mfa), 0);
    check("rstw_busy", 32'(busy), 0);
    check("rstw_done", 32'(done), 0);
    exp_rdata = 0; exp_rd_size = 0;
    check("rstw_rdata", rdata, 0);
    tick();
    check("rstw_done2", 32'(done), 0);
    check("rstw_mfa2", 32'(mem_mfa), 0);

    // REQ held high with instant acknowledge: WAIT, DONE, IDLE repeating.
    req = 1'b1; rw = 1'b1; addr = 32'h10; data_size = 2'b10; mem_moc = 1'b1;
    dcnt = 0; mcnt = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      mem_din = dword(32'h10);
      check("hold_mfa", 32'(mem_mfa), 32'(i % 3 == 0));
      check("hold_done", 32'(done), 32'(i % 3 == 1));
      dcnt += int'(done);
      mcnt += int'(mem_mfa);
      if (i == 11) begin
        req = 1'b0;
        mem_moc = 1'b0;
      end
    end
    check("hold_done_cnt", 32'(dcnt), 4);
    check("hold_mfa_cnt", 32'(mcnt), 4);
    exp_rdata = {gmem[19], gmem[18], gmem[17], gmem[16]};
    exp_rd_size = 2'b10;
    check("hold_rdata", rdata, exp_rdata);
    tick();
    check("hold_idle", 32'(busy), 0);

    for (int t = 0; t < 80; t++) begin
      logic [31:0] ra;
      logic [1:0]  rs;
      int          mo;
      rs = 2'($urandom_range(0, 9) == 0 ? 3 : $urandom_range(0, 2));
      ra = $urandom;
      if ($urandom_range(0, 3) != 0) ra = ra & ~((32'd1 << rs) - 1);
      mo = (($urandom_range(0, 5) == 0) ? $urandom_range(TMO - 1, TMO + 3)
                                        : $urandom_range(1, 4));
      access(1'($urandom), ra, rs, $urandom, mo);
      repeat ($urandom_range(0, 2)) tick();
    end

    for (int i = 0; i < 16; i++)
      check("mem_image", {dmem[4*i+3], dmem[4*i+2], dmem[4*i+1], dmem[4*i]},
                         {gmem[4*i+3], gmem[4*i+2], gmem[4*i+1], gmem[4*i]});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
